ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Multi-cycle multiply/divide unit that sits beside the EX-stage ALU of the MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and owns the architectural HI/LO registers.
- Stalls the pipeline through stallreq_o while an operation is in flight.
- Generalises the single-cycle ALU: parametrised data width and multiply latency, an iterative divider, and flush support.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits.
MUL_LAT, 2, cycles spent in the MUL state (≥1); product is computed combinationally and held via a latency counter.
OP_W, 3, width of op_i.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
start_i  in  1  operation request from EX; sampled only in IDLE.
op_i  in  OP_W  encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op.
opa_i  in  DATA_W  rs value (dividend / multiplicand / MT source).
opb_i  in  DATA_W  rt value (divisor / multiplier).
flush_i  in  1  abort the current operation (exception or branch flush).
busy_o  out  1  high in states MUL and DIV.
stallreq_o  out  1  pipeline stall request.
done_o  out  1  one-cycle pulse when HI/LO were just updated by mul/div.
hi_o  out  DATA_W  current HI (MFHI source).
lo_o  out  DATA_W  current LO (MFLO source).

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0; hi_o=lo_o=0; busy_o=stallreq_o=done_o=0; partial remainder and quotient registers cleared. Reset mid-operation discards the operation; no done_o pulse is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1, flush_i=0:
  - MTHI/MTLO: hi/lo←opa_i at the clock edge; stay IDLE; no stall; no done_o.
  - MULT/MULTU: latch operands → MUL with counter=MUL_LAT-1.
  - DIV/DIVU, opb_i≠0: latch operands → DIV with counter=DATA_W-1.
  - DIV/DIVU, opb_i=0: → DONE with LO=all-ones, HI=opa_i (defined divide-by-zero result).
  - Undefined op: ignored.
- IDLE, start_i=1, flush_i=1: request ignored.
- MUL: counter decrements each cycle; at counter=0 write the 2·DATA_W product → {HI,LO} and go to DONE.
  - MULT is signed; MULTU is unsigned.
  - Total latency: start cycle 0, done_o in cycle MUL_LAT+1.
- DIV: restoring divide, one quotient bit per cycle on magnitudes.
  - Signed DIV: operands are negated if negative. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - After DATA_W iterations, LO←quotient, HI←remainder, go to DONE. done_o is in cycle DATA_W+1.
  - Most-negative ÷ −1: quotient wraps to most-negative, remainder 0.
- DONE: done_o=1, stallreq_o=0; unconditionally → IDLE next cycle. A start_i presented in DONE is ignored; EX re-presents it in IDLE.
- stallreq_o:
  - Combinational 1 in IDLE when start_i=1, flush_i=0 and op is mul/div (including divide-by-zero).
  - 1 throughout MUL and DIV.
  - 0 in DONE and otherwise.
- flush_i in MUL or DIV: → IDLE at the next edge; HI/LO unchanged; no done_o; stallreq_o drops combinationally in that cycle. flush_i in DONE has no effect, because HI/LO are already committed.
- hi_o/lo_o are registered outputs and change only at the commit edge, on MTHI/MTLO, or on reset.
- All arithmetic is modulo widths: the product is 2·DATA_W bits; quotient and remainder are DATA_W bits.

Test Plan:
- DATA_W=32, MUL_LAT=2; MULT opa=0xFFFFFFFD (−3), opb=5 → stallreq_o high cycles 0–2; done_o cycle 3; HI=0xFFFFFFFF, LO=0xFFFFFFF1. The same operands with MULTU → HI=0x00000004, LO=0xFFFFFFF1.
- DIVU 100/7 → busy_o cycles 1–32, done_o cycle 33, LO=0x0000000E, HI=0x00000002. DIV 0xFFFFFFF9 (−7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0; DIVU 5/0 → done_o cycle 1, LO=0xFFFFFFFF, HI=5, stallreq_o high only in cycle 0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → hi_o/lo_o update one edge after each start; stallreq_o never asserted; done_o stays 0.
- DIVU started with HI=0xAAAA, LO=0x5555; flush_i at cycle 10 → IDLE at cycle 11, busy_o=0, HI/LO unchanged, no done_o; the next MULTU 3×4 yields LO=12.
- rst asserted asynchronously mid-DIV (between edges) → outputs clear immediately; after release, state is IDLE and start_i is accepted on the first edge.

Source files
------------

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU; owns HI/LO and
// stalls the pipeline while a MULT/MULTU/DIV/DIVU is in flight.
module ex_muldiv #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2,
  parameter int OP_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              stallreq_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(5);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  // opa_q holds the multiplicand, or the dividend shifting into the quotient.
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                mul_signed_q, mul_signed_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;

  logic                is_muldiv;
  logic                div_signed;
  logic [DATA_W-1:0]   opa_mag, opb_mag;
  logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext, product;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   rem_step, quo_step;
  logic [DATA_W-1:0]   quo_final, rem_final;

  assign is_muldiv  = (op_i == OP_MULT) || (op_i == OP_MULTU) ||
                      (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign div_signed = (op_i == OP_DIV);
  assign opa_mag    = (div_signed && opa_i[DATA_W-1]) ? -opa_i : opa_i;
  assign opb_mag    = (div_signed && opb_i[DATA_W-1]) ? -opb_i : opb_i;

  // Sign- or zero-extending to 2*DATA_W makes the truncated product correct for both.
  assign mul_a_ext = mul_signed_q ? {{DATA_W{opa_q[DATA_W-1]}}, opa_q}
                                  : {{DATA_W{1'b0}}, opa_q};
  assign mul_b_ext = mul_signed_q ? {{DATA_W{opb_q[DATA_W-1]}}, opb_q}
                                  : {{DATA_W{1'b0}}, opb_q};
  assign product   = mul_a_ext * mul_b_ext;

  // One restoring step: shift the next dividend bit into the remainder and try the subtract.
  assign trial = {rem_q, opa_q[DATA_W-1]} - {1'b0, opb_q};

  always_comb begin
    if (!trial[DATA_W]) begin
      rem_step = trial[DATA_W-1:0];
      quo_step = {opa_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_step = {rem_q[DATA_W-2:0], opa_q[DATA_W-1]};
      quo_step = {opa_q[DATA_W-2:0], 1'b0};
    end
  end

  assign quo_final = q_neg_q ? -quo_step : quo_step;
  assign rem_final = r_neg_q ? -rem_step : rem_step;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rem_d        = rem_q;
    mul_signed_d = mul_signed_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          case (op_i)
            OP_MTHI: hi_d = opa_i;
            OP_MTLO: lo_d = opa_i;
            OP_MULT, OP_MULTU: begin
              opa_d        = opa_i;
              opb_d        = opb_i;
              mul_signed_d = (op_i == OP_MULT);
              cnt_d        = CNT_W'(MUL_LAT - 1);
              state_d      = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (opb_i == '0) begin
                lo_d    = '1;
                hi_d    = opa_i;
                state_d = S_DONE;
              end else begin
                opa_d   = opa_mag;
                opb_d   = opb_mag;
                rem_d   = '0;
                q_neg_d = div_signed && (opa_i[DATA_W-1] ^ opb_i[DATA_W-1]);
                r_neg_d = div_signed && opa_i[DATA_W-1];
                cnt_d   = CNT_W'(DATA_W - 1);
                state_d = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = product[2*DATA_W-1:DATA_W];
          lo_d    = product[DATA_W-1:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DIV: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          opa_d = quo_step;
          rem_d = rem_step;
          if (cnt_q == '0) begin
            lo_d    = quo_final;
            hi_d    = rem_final;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too; a reset mid-divide must
      // leave no stale partial remainder or quotient behind.
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rem_q        <= '0;
      mul_signed_q <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rem_q        <= rem_d;
      mul_signed_q <= mul_signed_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
    end
  end

  assign busy_o     = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o     = (state_q == S_DONE);
  assign stallreq_o = ((state_q == S_IDLE) && start_i && !flush_i && is_muldiv) ||
                      (busy_o && !flush_i);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vectors, with HI/LO results and
// completion cycles checked by a scoreboard monitor on done_o.
module tb_ex_muldiv;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam int         MUL_LAT  = 2;
  localparam int         DATA_W   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        flush_i;
  logic        busy_o;
  logic        stallreq_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_pass  = 0;

  ex_muldiv #(.DATA_W(32), .MUL_LAT(MUL_LAT), .OP_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .stallreq_o (stallreq_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done_o pulse must match the oldest expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done_o), 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, 64'(hi_o), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo_o), 64'(e.lo));
        check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called just after a rising edge; that cycle is cycle 0 of the operation.
  // lat is the number of busy cycles (0 for divide-by-zero).
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input int lat);
    int t0;
    start_i = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    t0      = cyc;
    sb.push_back('{hi: hi, lo: lo, cyc: t0 + lat + 1, name: name});
    for (int k = 0; k <= lat + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s_stall_c%0d", name, k), 64'(stallreq_o), 64'(k <= lat));
      check($sformatf("%s_busy_c%0d", name, k), 64'(busy_o), 64'(k >= 1 && k <= lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    op_i    = 3'd0;
    opa_i   = '0;
    opb_i   = '0;
    flush_i = 1'b0;

    #12;
    check("rst_busy",  64'(busy_o),     64'd0);
    check("rst_stall", 64'(stallreq_o), 64'd0);
    check("rst_done",  64'(done_o),     64'd0);
    check("rst_hi",    64'(hi_o),       64'd0);
    check("rst_lo",    64'(lo_o),       64'd0);
    @(posedge clk); #1; rst = 1'b0;

    @(posedge clk); #1;
    do_op("mult_m3x5",  OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
    @(posedge clk); #1;
    do_op("multu_m3x5", OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, MUL_LAT);
    @(posedge clk); #1;
    do_op("mult_minsq", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_LAT);
    @(posedge clk); #1;
    do_op("divu_100_7", OP_DIVU,  32'd100, 32'd7, 32'h2, 32'hE, DATA_W);
    @(posedge clk); #1;
    do_op("div_m7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DATA_W);
    @(posedge clk); #1;
    do_op("div_7_m2",   OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, DATA_W);
    @(posedge clk); #1;
    do_op("div_min_m1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DATA_W);
    @(posedge clk); #1;
    do_op("divu_big",   OP_DIVU,  32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, DATA_W);
    @(posedge clk); #1;
    do_op("divu_5_0",   OP_DIVU,  32'd5, 32'd0, 32'h5, 32'hFFFF_FFFF, 0);

    // MTHI then MTLO on consecutive cycles.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = OP_MTHI; opa_i = 32'h1234_5678;
    @(negedge clk);
    check("mthi_stall_c0", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    op_i = OP_MTLO; opa_i = 32'h9ABC_DEF0;
    @(negedge clk);
    check("mthi_hi_c1",    64'(hi_o),       64'h1234_5678);
    check("mtlo_stall_c1", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("mtlo_lo_c2", 64'(lo_o), 64'h9ABC_DEF0);
    check("mtlo_hi_c2", 64'(hi_o), 64'h1234_5678);

    // Flush mid-divide leaves HI/LO untouched.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = OP_MTHI; opa_i = 32'h0000_AAAA;
    @(posedge clk); #1;
    op_i = OP_MTLO; opa_i = 32'h0000_5555;
    @(posedge clk); #1;
    op_i = OP_DIVU; opa_i = 32'd1000; opb_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_stall_c10", 64'(stallreq_o), 64'd0);
    check("flush_busy_c10",  64'(busy_o),     64'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy_c11",  64'(busy_o),     64'd0);
    check("flush_stall_c11", 64'(stallreq_o), 64'd0);
    check("flush_hi_c11",    64'(hi_o),       64'h0000_AAAA);
    check("flush_lo_c11",    64'(lo_o),       64'h0000_5555);
    @(posedge clk); #1;
    do_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, MUL_LAT);

    // Asynchronous reset between edges in the middle of a divide.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = OP_DIVU; opa_i = 32'd100; opb_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy",  64'(busy_o),     64'd0);
    check("arst_stall", 64'(stallreq_o), 64'd0);
    check("arst_done",  64'(done_o),     64'd0);
    check("arst_hi",    64'(hi_o),       64'd0);
    check("arst_lo",    64'(lo_o),       64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op("post_rst_multu", OP_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, MUL_LAT);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
